// File: rtl/speicher_steuerung.sv
// Memory access controller between the load/store stage and a synchronous single-port RAM.
// Handles word loads/stores, byte-masked read-modify-write, one IO output register and range errors.
module speicher_steuerung #(
   parameter int unsigned          WORDSIZE   = 32,
   parameter int unsigned          WORDS      = 256,
   parameter int unsigned          ADDRWIDTH  = 32,
   parameter logic [ADDRWIDTH-1:0] IO_ADRESSE = 32'h8000_0000
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       Start,
   input  logic                       Schreiben,
   input  logic [ADDRWIDTH-1:0]       Adresse,
   input  logic [WORDSIZE-1:0]        DatenRein,
   input  logic [WORDSIZE/8-1:0]      ByteMaske,
   output logic                       Bereit,
   output logic                       Fertig,
   output logic                       Fehler,
   output logic [WORDSIZE-1:0]        DatenRaus,
   output logic                       RamSchreibenAn,
   output logic [$clog2(WORDS)-1:0]   RamAdresse,
   output logic [WORDSIZE-1:0]        RamDatenRein,
   input  logic [WORDSIZE-1:0]        RamDatenRaus,
   output logic [WORDSIZE-1:0]        IoAusgang
);

   localparam int unsigned          AW      = $clog2(WORDS);
   localparam int unsigned          NB      = WORDSIZE / 8;
   localparam logic [ADDRWIDTH-1:0] WORDS_A = ADDRWIDTH'(WORDS);

   typedef enum logic [2:0] {
      LEERLAUF,
      LESEN,
      WARTEN,
      SCHREIBEN,
      FERTIG
   } zustand_t;

   zustand_t            zustand, zustand_naechst;
   logic [WORDSIZE-1:0] daten_reg;
   logic [NB-1:0]       maske_reg;
   logic                schreiben_reg;
   logic                fehler_reg;

   logic annahme, io_treffer, bereich_fehler, maske_voll, maske_leer;

   function automatic logic [WORDSIZE-1:0] mischen(input logic [WORDSIZE-1:0] alt,
                                                   input logic [WORDSIZE-1:0] neu,
                                                   input logic [NB-1:0]       m);
      logic [WORDSIZE-1:0] r;
      r = alt;
      for (int unsigned i = 0; i < NB; i++) begin
         if (m[i]) r[8*i +: 8] = neu[8*i +: 8];
      end
      return r;
   endfunction

   // Decode uses the live request inputs: the routing decision is made on the accept edge.
   always_comb begin
      annahme        = (zustand == LEERLAUF) && Start;
      io_treffer     = (Adresse == IO_ADRESSE);
      bereich_fehler = !io_treffer && (Adresse >= WORDS_A);
      maske_voll     = &ByteMaske;
      maske_leer     = ~|ByteMaske;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) zustand <= LEERLAUF;
      else       zustand <= zustand_naechst;
   end

   always_comb begin
      zustand_naechst = zustand;
      Bereit          = 1'b0;
      Fertig          = 1'b0;
      Fehler          = 1'b0;
      RamSchreibenAn  = 1'b0;
      unique case (zustand)
         LEERLAUF: begin
            Bereit = 1'b1;
            if (Start) begin
               if (io_treffer || bereich_fehler) zustand_naechst = FERTIG;
               else if (Schreiben && maske_voll) zustand_naechst = SCHREIBEN;
               else if (Schreiben && maske_leer) zustand_naechst = FERTIG;
               else                              zustand_naechst = LESEN;
            end
         end
         LESEN:     zustand_naechst = WARTEN;
         WARTEN:    zustand_naechst = schreiben_reg ? SCHREIBEN : FERTIG;
         SCHREIBEN: begin
            RamSchreibenAn  = 1'b1;
            zustand_naechst = FERTIG;
         end
         FERTIG: begin
            Fertig          = 1'b1;
            Fehler          = fehler_reg;
            zustand_naechst = LEERLAUF;
         end
         default:   zustand_naechst = LEERLAUF;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         daten_reg     <= '0;
         maske_reg     <= '0;
         schreiben_reg <= 1'b0;
         fehler_reg    <= 1'b0;
         DatenRaus     <= '0;
         IoAusgang     <= '0;
         RamAdresse    <= '0;
         RamDatenRein  <= '0;
      end else begin
         if (annahme) begin
            daten_reg     <= DatenRein;
            maske_reg     <= ByteMaske;
            schreiben_reg <= Schreiben;
            fehler_reg    <= bereich_fehler;
            if (io_treffer) begin
               if (Schreiben) IoAusgang <= mischen(IoAusgang, DatenRein, ByteMaske);
               else           DatenRaus <= IoAusgang;
            end else if (bereich_fehler) begin
               if (!Schreiben) DatenRaus <= '0;
            end else begin
               RamAdresse <= Adresse[AW-1:0];
               if (Schreiben && maske_voll) RamDatenRein <= DatenRein;
            end
         end
         // RAM data read during LESEN is valid here; partial stores merge into the write word.
         if (zustand == WARTEN) begin
            if (schreiben_reg) RamDatenRein <= mischen(RamDatenRaus, daten_reg, maske_reg);
            else               DatenRaus    <= RamDatenRaus;
         end
      end
   end

endmodule

// File: tb/tb_speicher_steuerung.sv
// Directed bench for speicher_steuerung with a behavioural synchronous RAM.
// Expected values are hand-computed; each check is an immediate assertion.
module tb_speicher_steuerung;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic        Schreiben = 1'b0;
   logic [31:0] Adresse = '0;
   logic [31:0] DatenRein = '0;
   logic [3:0]  ByteMaske = '0;
   logic        Bereit, Fertig, Fehler, RamSchreibenAn;
   logic [31:0] DatenRaus, RamDatenRein, IoAusgang;
   logic [31:0] RamDatenRaus;
   logic [7:0]  RamAdresse;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [256];

   speicher_steuerung #(
      .WORDSIZE   (32),
      .WORDS      (256),
      .ADDRWIDTH  (32),
      .IO_ADRESSE (32'h8000_0000)
   ) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .Start          (Start),
      .Schreiben      (Schreiben),
      .Adresse        (Adresse),
      .DatenRein      (DatenRein),
      .ByteMaske      (ByteMaske),
      .Bereit         (Bereit),
      .Fertig         (Fertig),
      .Fehler         (Fehler),
      .DatenRaus      (DatenRaus),
      .RamSchreibenAn (RamSchreibenAn),
      .RamAdresse     (RamAdresse),
      .RamDatenRein   (RamDatenRein),
      .RamDatenRaus   (RamDatenRaus),
      .IoAusgang      (IoAusgang)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      if (RamSchreibenAn) mem[RamAdresse] <= RamDatenRein;
      RamDatenRaus <= mem[RamAdresse];
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one request and measures completion cycle, Fehler and RAM write activity.
   task automatic do_req(input string tag, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, input int lat,
                         input bit exp_err, input int exp_wr, input logic [7:0] exp_wadr);
      int          got_lat = 0;
      int          wrs     = 0;
      logic        err_seen = 1'b0;
      logic [7:0]  wadr     = '0;
      @(negedge Clock);
      chk({tag, "_bereit"}, 32'(Bereit), 32'd1);
      Start = 1'b1; Schreiben = wr; Adresse = a; DatenRein = d; ByteMaske = m;
      @(posedge Clock);
      @(negedge Clock);
      Start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (RamSchreibenAn) begin
            wrs++;
            wadr = RamAdresse;
         end
         if (Fertig) begin
            got_lat  = c;
            err_seen = Fehler;
            break;
         end
         @(negedge Clock);
      end
      chk({tag, "_latenz"}, 32'(got_lat), 32'(lat));
      chk({tag, "_fehler"}, 32'(err_seen), 32'(exp_err));
      chk({tag, "_ramwr"}, 32'(wrs), 32'(exp_wr));
      if (exp_wr != 0) chk({tag, "_ramadr"}, 32'(wadr), 32'(exp_wadr));
   endtask

   initial begin
      int fertig_cnt;
      int fertig_at;

      #2;
      chk("rst_bereit", 32'(Bereit), 32'd1);
      chk("rst_fertig", 32'(Fertig), 32'd0);
      chk("rst_fehler", 32'(Fehler), 32'd0);
      chk("rst_daten", DatenRaus, 32'd0);
      chk("rst_io", IoAusgang, 32'd0);
      chk("rst_ramwe", 32'(RamSchreibenAn), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;

      do_req("st5", 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 2, 1'b0, 1, 8'd5);
      chk("st5_mem", mem[5], 32'hDEADBEEF);
      do_req("ld5", 1'b0, 32'd5, 32'h0, 4'h0, 3, 1'b0, 0, 8'd0);
      chk("ld5_daten", DatenRaus, 32'hDEADBEEF);

      do_req("pst5", 1'b1, 32'd5, 32'h11223344, 4'b0101, 4, 1'b0, 1, 8'd5);
      do_req("ld5b", 1'b0, 32'd5, 32'h0, 4'hF, 3, 1'b0, 0, 8'd0);
      chk("ld5b_daten", DatenRaus, 32'hDE22BE44);

      do_req("leer5", 1'b1, 32'd5, 32'hFFFFFFFF, 4'h0, 1, 1'b0, 0, 8'd0);
      chk("leer5_mem", mem[5], 32'hDE22BE44);

      do_req("io_st", 1'b1, 32'h8000_0000, 32'd1, 4'hF, 1, 1'b0, 0, 8'd0);
      chk("io_st_wert", IoAusgang, 32'd1);
      do_req("io_ld", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1, 1'b0, 0, 8'd0);
      chk("io_ld_daten", DatenRaus, 32'd1);
      do_req("io_pst", 1'b1, 32'h8000_0000, 32'hAABBCCDD, 4'b1000, 1, 1'b0, 0, 8'd0);
      chk("io_pst_wert", IoAusgang, 32'hAA000001);

      do_req("st255", 1'b1, 32'd255, 32'hCAFEF00D, 4'hF, 2, 1'b0, 1, 8'd255);
      do_req("ld255", 1'b0, 32'd255, 32'h0, 4'h0, 3, 1'b0, 0, 8'd0);
      chk("ld255_daten", DatenRaus, 32'hCAFEF00D);

      do_req("ld256", 1'b0, 32'd256, 32'h0, 4'h0, 1, 1'b1, 0, 8'd0);
      chk("ld256_daten", DatenRaus, 32'd0);
      do_req("st44", 1'b1, 32'd44, 32'h12345678, 4'hF, 2, 1'b0, 1, 8'd44);
      do_req("st300", 1'b1, 32'd300, 32'h99999999, 4'hF, 1, 1'b1, 0, 8'd0);
      do_req("ld44", 1'b0, 32'd44, 32'h0, 4'h0, 3, 1'b0, 0, 8'd0);
      chk("ld44_daten", DatenRaus, 32'h12345678);

      // Start held high through a load; later requests must be ignored until completion.
      @(negedge Clock);
      Start = 1'b1; Schreiben = 1'b0; Adresse = 32'd5;
      @(posedge Clock);
      fertig_cnt = 0;
      fertig_at  = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge Clock);
         Adresse = 32'd255;
         if (Fertig) begin
            fertig_cnt++;
            if (fertig_at == 0) fertig_at = c;
         end
         if (c == 3) Start = 1'b0;
      end
      chk("burst_anzahl", 32'(fertig_cnt), 32'd1);
      chk("burst_latenz", 32'(fertig_at), 32'd3);
      chk("burst_daten", DatenRaus, 32'hDE22BE44);

      // Reset asserted while SCHREIBEN is active.
      @(negedge Clock);
      Start = 1'b1; Schreiben = 1'b1; Adresse = 32'd5; DatenRein = 32'h55555555; ByteMaske = 4'hF;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      chk("rs_we_vorher", 32'(RamSchreibenAn), 32'd1);
      #1;
      Reset = 1'b1;
      #1;
      chk("rs_we_nachher", 32'(RamSchreibenAn), 32'd0);
      chk("rs_bereit", 32'(Bereit), 32'd1);
      chk("rs_io", IoAusgang, 32'd0);
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      do_req("rs_ld5", 1'b0, 32'd5, 32'h0, 4'h0, 3, 1'b0, 0, 8'd0);
      chk("rs_ld5_daten", DatenRaus, 32'hDE22BE44);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
